// File: rtl/pran_dump_pkg.sv
// Shared types and UART framing constants for the data-memory dump engine.
// No logic; no latency; no flow control.
package pran_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        FETCH,
        SEND,
        NEXT,
        FINISH
    } dump_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   BYTE_IDX_W = 2;

    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer; tx is a flop, idle high.
// Latency: start bit appears on the edge that accepts the byte; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: ready drops on acceptance and returns in the final stop-bit cycle, allowing gapless chaining.
module uart_tx_byte
    import pran_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_STOP = 4'(DATA_BITS + 1);

    logic                 active_q, active_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS:0]   frame_q, frame_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
    logic                 stop_end;

    always_comb begin
        bit_end   = (clk_cnt_q == CNT_LAST);
        stop_end  = active_q && bit_end && (bit_idx_q == BIT_STOP);
        ready     = !active_q || stop_end;
        active_d  = active_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        tx_d      = tx_q;
        if (valid && ready) begin
            // Accepting in the last stop cycle lets the next start bit follow with no idle gap.
            active_d  = 1'b1;
            clk_cnt_d = '0;
            bit_idx_d = '0;
            frame_d   = {STOP_BIT, data};
            tx_d      = START_BIT;
        end else if (stop_end) begin
            active_d  = 1'b0;
            clk_cnt_d = '0;
            tx_d      = STOP_BIT;
        end else if (active_q) begin
            if (bit_end) begin
                clk_cnt_d = '0;
                bit_idx_d = bit_idx_q + 4'd1;
                tx_d      = frame_q[0];
                frame_d   = {1'b0, frame_q[DATA_BITS:1]};
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q  <= 1'b0;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
            tx_q      <= STOP_BIT;
        end else begin
            active_q  <= active_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/mem_dump_tx.sv
// Data-memory readback over UART: holds the CPU in reset and sends WORD_COUNT words LSB byte first.
// Latency: first start bit 3 cycles after start; DUMP_CSUM_EN appends a mod-256 byte-sum frame.
// Backpressure: paced by the serializer's ready; start is ignored unless idle.
module mem_dump_tx
    import pran_dump_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] START_ADR    = 32'h0000_0000,
    parameter int          WORD_COUNT   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ReadData,
    output logic        cpu_hold,
    output logic [31:0] dump_adr,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LAST_WORD = 16'(WORD_COUNT - 1);

    dump_state_e state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] word_q, word_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    byte_idx_t   byte_idx_q, byte_idx_d;
    logic        inflight_q, inflight_d;
    logic        hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        byte_vld;
    logic        byte_rdy;
    logic [7:0]  byte_dat;
`ifdef DUMP_CSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic        csum_phase_q, csum_phase_d;
`endif

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        inflight_d = inflight_q;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_vld   = 1'b0;
        // While a byte is in flight the serializer can only take the following byte.
        byte_dat   = inflight_q ? word_q[15:8] : word_q[7:0];
`ifdef DUMP_CSUM_EN
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HOLD;
                    hold_d     = 1'b1;
                    busy_d     = 1'b1;
                    adr_d      = START_ADR;
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    inflight_d = 1'b0;
`ifdef DUMP_CSUM_EN
                    csum_d       = '0;
                    csum_phase_d = 1'b0;
`endif
                end
            end
            HOLD: state_d = FETCH;
            FETCH: begin
                word_d     = ReadData;
                byte_idx_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (!inflight_q) begin
                    byte_vld = 1'b1;
                    if (byte_rdy) begin
                        inflight_d = 1'b1;
                    end
                end else if (byte_rdy) begin
                    word_d = {8'h00, word_q[31:8]};
`ifdef DUMP_CSUM_EN
                    if (!csum_phase_q) begin
                        csum_d = csum_q + word_q[7:0];
                    end
`endif
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        byte_vld   = 1'b1;
                    end else begin
                        inflight_d = 1'b0;
                        state_d    = NEXT;
                    end
                end
            end
            NEXT: begin
                if (word_cnt_q == LAST_WORD) begin
`ifdef DUMP_CSUM_EN
                    if (!csum_phase_q) begin
                        // Reuse SEND as a one-byte word carrying the sum.
                        csum_phase_d = 1'b1;
                        word_d       = {24'h0, csum_q};
                        byte_idx_d   = 2'd3;
                        state_d      = SEND;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = FINISH;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
`endif
                end else begin
                    adr_d      = adr_q + 32'd4;
                    word_cnt_d = word_cnt_q + 16'd1;
                    state_d    = FETCH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            adr_q      <= START_ADR;
            word_q     <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            inflight_q <= 1'b0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            inflight_q <= inflight_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef DUMP_CSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
        end else begin
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
        end
    end
`endif

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .reset(reset),
        .valid(byte_vld),
        .data (byte_dat),
        .ready(byte_rdy),
        .tx   (tx)
    );

    assign cpu_hold = hold_q;
    assign dump_adr = adr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: a queue-based line model checks a wrapping 3-word dump every cycle,
// and a second single-word instance is pinned against hand-written frame bits.
module tb_mem_dump_tx;

    localparam int          C     = 4;
    localparam logic [31:0] SA    = 32'hFFFF_FFF8;
    localparam int          WC    = 3;
    localparam int          DFRMS = 4 * WC;

    logic        clk = 1'b0;
    logic        reset, start, start_one;
    logic [31:0] read_data, read_data_one, dump_adr, dump_adr_one;
    logic        cpu_hold, tx, busy, done;
    logic        hold_one, tx_one, busy_one, done_one;
    logic [31:0] mem [0:3];
    logic [31:0] offs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_dump_tx #(.CLKS_PER_BIT(C), .START_ADR(SA), .WORD_COUNT(WC)) u_dut (
        .clk(clk), .reset(reset), .start(start), .ReadData(read_data),
        .cpu_hold(cpu_hold), .dump_adr(dump_adr), .tx(tx), .busy(busy), .done(done)
    );

    mem_dump_tx #(.CLKS_PER_BIT(C), .START_ADR(32'h0), .WORD_COUNT(1)) u_one (
        .clk(clk), .reset(reset), .start(start_one), .ReadData(read_data_one),
        .cpu_hold(hold_one), .dump_adr(dump_adr_one), .tx(tx_one), .busy(busy_one), .done(done_one)
    );

    always_comb begin
        offs      = dump_adr - SA;
        read_data = 32'hDEAD_BEEF;
        if (offs[1:0] == 2'b00 && offs < 32'(4 * WC)) read_data = mem[offs[3:2]];
    end
    assign read_data_one = (dump_adr_one == 32'h0) ? 32'h1234_5678 : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Line model: expected byte queue built from memory when a start is accepted.
    logic [7:0] exp_q [$];
    logic [7:0] cur_byte;
    logic [7:0] sum;
    logic [31:0] w;
    bit  active = 1'b0, in_frame = 1'b0, just_ended = 1'b0;
    int  cyc = 0, first_at = 0, fcyc = 0, nframes = 0, last_end = 0, bit_no;
    logic eb;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            active     = 1'b0;
            in_frame   = 1'b0;
            just_ended = 1'b0;
            exp_q.delete();
        end else begin
            if (in_frame) begin
                bit_no = fcyc / C;
                if (bit_no == 0) eb = 1'b0;
                else if (bit_no == 9) eb = 1'b1;
                else eb = cur_byte[bit_no-1];
                chk("tx_bit", {31'b0, tx}, {31'b0, eb});
                fcyc++;
                if (fcyc == 10 * C) begin
                    in_frame   = 1'b0;
                    nframes++;
                    just_ended = 1'b1;
                    last_end   = cyc;
                end
            end else begin
                if (cyc == first_at || (just_ended && nframes % 4 != 0 && nframes < DFRMS))
                    chk("tx_start_due", {31'b0, tx}, 32'd0);
                else if (!active || exp_q.size() == 0 || cyc < first_at)
                    chk("tx_idle", {31'b0, tx}, 32'd1);
                if (tx == 1'b0 && active && exp_q.size() != 0 && cyc >= first_at) begin
                    if (nframes % 4 == 0 && nframes < DFRMS)
                        chk("dump_adr", dump_adr, SA + 32'(4 * (nframes / 4)));
                    cur_byte = exp_q.pop_front();
                    in_frame = 1'b1;
                    fcyc     = 1;
                end
                just_ended = 1'b0;
            end
            if (done) begin
                chk("done_legal", {31'b0, (active && !in_frame && exp_q.size() == 0 &&
                    cyc - last_end >= 1 && cyc - last_end <= 6)}, 32'd1);
                chk("busy_at_done", {31'b0, busy}, 32'd0);
                chk("hold_at_done", {31'b0, cpu_hold}, 32'd0);
                active = 1'b0;
            end else begin
                chk("busy", {31'b0, busy}, {31'b0, active});
                chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, active});
            end
            if (start && !active && !done) begin
                active   = 1'b1;
                first_at = cyc + 4;
                nframes  = 0;
                sum      = 8'h00;
                exp_q.delete();
                for (int k = 0; k < WC; k++) begin
                    w = mem[k];
                    for (int b = 0; b < 4; b++) begin
                        exp_q.push_back(w[8*b +: 8]);
                        sum = sum + w[8*b +: 8];
                    end
                end
`ifdef DUMP_CSUM_EN
                exp_q.push_back(sum);
`endif
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        int n = 0;
        bit got = 1'b0;
        while (n < 3000 && !got) begin
            @(posedge clk); #2;
            n++;
            if (done) begin
                got = 1'b1;
                if (poke) start = 1'b1;
            end
        end
        chk("done_seen", {31'b0, got}, 32'd1);
        @(posedge clk); #2 start = 1'b0;
    endtask

    // Single-word instance checked cycle by cycle against literal frame bits.
    task automatic run_one();
        logic [7:0] bytes [0:4];
        logic [7:0] cb;
        int nb, t, tgt, end_t;
        bit got;
        logic xb;
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
`ifdef DUMP_CSUM_EN
        nb = 5;
`else
        nb = 4;
`endif
        @(posedge clk); #2 start_one = 1'b1;
        @(negedge clk); t = 0;
        @(posedge clk); #2 start_one = 0;
        for (int b = 0; b < nb; b++) begin
            cb = bytes[b];
            for (int i = 0; i < 10; i++) begin
                xb = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : cb[i-1];
                for (int j = 0; j < C; j++) begin
                    tgt = 4 + 10 * C * b + C * i + j;
                    while (t < tgt) begin @(negedge clk); t++; end
                    chk("one_tx", {31'b0, tx_one}, {31'b0, xb});
                    if (j == 0 && i == 5) chk("one_hold", {31'b0, hold_one}, 32'd1);
                end
            end
        end
        end_t = 4 + 10 * C * nb - 1;
        got = 1'b0;
        while (t < end_t + 6 && !got) begin
            @(negedge clk); t++;
            if (done_one) begin
                got = 1'b1;
                chk("one_busy_at_done", {31'b0, busy_one}, 32'd0);
                chk("one_hold_at_done", {31'b0, hold_one}, 32'd0);
            end
        end
        chk("one_done_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
        chk("one_done_pulse", {31'b0, done_one}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_one = 1'b0;
        mem[0] = 32'h0000_00FF; mem[1] = 32'hAABB_CCDD; mem[2] = 32'hFFFF_FFFF; mem[3] = 32'h0;
        #3 reset = 1'b0;
        #1;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_hold", {31'b0, cpu_hold}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_adr", dump_adr, SA);
        chk("rst_one_tx", {31'b0, tx_one}, 32'd1);
        chk("rst_one_adr", dump_adr_one, 32'h0);
        @(posedge clk); #2 reset = 1'b1;
        repeat (3) @(posedge clk);

        // Full dump with wrap; memory changes after the fetch and a start while busy must not matter.
        pulse_start();
        repeat (8) @(posedge clk);
        #2 mem[0] = 32'h5A5A_5A5A;
        repeat (40) pulse_start();
        wait_done(1'b1);
        repeat (20) @(posedge clk);
        #2 chk("no_restart_after_done", {31'b0, busy}, 32'd0);
        mem[0] = 32'h0000_00FF;

        // Reset mid-frame abandons the dump at once; the next dump starts over.
        pulse_start();
        repeat (50) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_tx", {31'b0, tx}, 32'd1);
        chk("mid_rst_hold", {31'b0, cpu_hold}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_adr", dump_adr, SA);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        pulse_start();
        wait_done(1'b0);
        repeat (5) @(posedge clk);

        run_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
